// File: rtl/seq_multiword_adder_pkg.sv
// Shared definitions for seq_multiword_adder: FSM state encoding and the
// chunk-counter width helper.
package seq_multiword_adder_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADD  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   typedef enum logic [1:0] {
      StIdle = IDLE,
      StAdd  = ADD,
      StDone = DONE
   } state_e;

   // Counter width is clog2(max(n, 2)) so a single-chunk build still has a 1-bit counter.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cl_adder_w_cin.sv
// Carry-lookahead adder with carry-in. Every carry is a flat sum of
// generate/propagate product terms rather than a ripple chain.
module cl_adder_w_cin #(
   parameter int unsigned Width = 4
) (
   input  logic [Width-1:0] a_i,
   input  logic [Width-1:0] b_i,
   input  logic             carry_i,
   output logic [Width-1:0] sum_o,
   output logic             carry_o
);

   logic [Width-1:0] gen;
   logic [Width-1:0] prop;
   logic [Width:0]   carry;
   logic             pp;
   logic             cc;

   assign gen  = a_i & b_i;
   assign prop = a_i ^ b_i;

   // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin.
   always_comb begin
      carry    = '0;
      pp       = 1'b0;
      cc       = 1'b0;
      carry[0] = carry_i;
      for (int i = 0; i < int'(Width); i++) begin
         cc = gen[i];
         pp = prop[i];
         for (int j = i - 1; j >= 0; j--) begin
            cc = cc | (pp & gen[j]);
            pp = pp & prop[j];
         end
         cc           = cc | (pp & carry_i);
         carry[i + 1] = cc;
      end
   end

   assign sum_o   = prop ^ carry[Width-1:0];
   assign carry_o = carry[Width];

endmodule

// File: rtl/seq_multiword_adder.sv
// Sequential multi-word adder: adds Width*Chunks-bit operands one Width-bit
// chunk per cycle through a single cl_adder_w_cin, carrying between chunks
// in a register. Optional subtract mode under SEQ_MULTIWORD_ADDER_SUB_EN.
module seq_multiword_adder
   import seq_multiword_adder_pkg::*;
#(
   parameter int unsigned Width  = 4,
   parameter int unsigned Chunks = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    valid_i,
   output logic                    ready_o,
   input  logic [Width*Chunks-1:0] a_i,
   input  logic [Width*Chunks-1:0] b_i,
   input  logic                    carry_i,
`ifdef SEQ_MULTIWORD_ADDER_SUB_EN
   input  logic                    sub_i,
`endif
   output logic                    valid_o,
   input  logic                    ready_i,
   output logic [Width*Chunks-1:0] result_o,
   output logic                    carry_o
);

   localparam int unsigned TotalW = Width * Chunks;
   localparam int unsigned CntW   = cnt_width(Chunks);

   state_e              state_q, state_d;
   logic [TotalW-1:0]   a_q, a_d;
   logic [TotalW-1:0]   b_q, b_d;
   logic [TotalW-1:0]   result_q, result_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                carry_q, carry_d;
   logic                carry_out_q, carry_out_d;
   logic                ready_q, ready_d;
   logic                valid_q, valid_d;
   logic [Width-1:0]    chunk_b;
   logic [Width-1:0]    chunk_sum;
   logic                chunk_cout;

`ifdef SEQ_MULTIWORD_ADDER_SUB_EN
   logic sub_q, sub_d;
   // Subtraction is A + ~B with the inverted borrow as the initial carry.
   assign chunk_b = b_q[Width-1:0] ^ {Width{sub_q}};
`else
   assign chunk_b = b_q[Width-1:0];
`endif

   cl_adder_w_cin #(
      .Width (Width)
   ) u_chunk_adder (
      .a_i     (a_q[Width-1:0]),
      .b_i     (chunk_b),
      .carry_i (carry_q),
      .sum_o   (chunk_sum),
      .carry_o (chunk_cout)
   );

   // Next-state logic: accept in IDLE, one chunk per cycle in ADD, hold in DONE.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      result_d    = result_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      carry_out_d = carry_out_q;
      ready_d     = ready_q;
      valid_d     = valid_q;
`ifdef SEQ_MULTIWORD_ADDER_SUB_EN
      sub_d       = sub_q;
`endif
      case (state_q)
         StIdle: begin
            ready_d = 1'b1;
            if (valid_i && ready_q) begin
               a_d     = a_i;
               b_d     = b_i;
               cnt_d   = '0;
               ready_d = 1'b0;
               state_d = StAdd;
`ifdef SEQ_MULTIWORD_ADDER_SUB_EN
               sub_d   = sub_i;
               carry_d = carry_i ^ sub_i;
`else
               carry_d = carry_i;
`endif
            end
         end
         StAdd: begin
            // Sum chunks enter at the MSB end so after Chunks shifts chunk 0 sits at the LSB.
            result_d                    = result_q >> Width;
            result_d[TotalW-1 -: Width] = chunk_sum;
            a_d                         = a_q >> Width;
            b_d                         = b_q >> Width;
            carry_d                     = chunk_cout;
            cnt_d                       = cnt_q + CntW'(1);
            if (cnt_q == CntW'(Chunks - 1)) begin
               state_d     = StDone;
               valid_d     = 1'b1;
               carry_out_d = chunk_cout;
            end
         end
         StDone: begin
            if (ready_i) begin
               valid_d = 1'b0;
               ready_d = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         carry_out_q <= 1'b0;
         ready_q     <= 1'b0;
         valid_q     <= 1'b0;
`ifdef SEQ_MULTIWORD_ADDER_SUB_EN
         sub_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         result_q    <= result_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         carry_out_q <= carry_out_d;
         ready_q     <= ready_d;
         valid_q     <= valid_d;
`ifdef SEQ_MULTIWORD_ADDER_SUB_EN
         sub_q       <= sub_d;
`endif
      end
   end

   assign ready_o  = ready_q;
   assign valid_o  = valid_q;
   assign result_o = result_q;
   assign carry_o  = carry_out_q;

endmodule

// File: tb/tb_seq_multiword_adder.sv
// Self-checking bench for seq_multiword_adder (Width=4, Chunks=4).
module tb_seq_multiword_adder;

   localparam int unsigned Width  = 4;
   localparam int unsigned Chunks = 4;
   localparam int unsigned TW     = Width * Chunks;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          valid_i;
   logic          ready_o;
   logic [TW-1:0] a_i;
   logic [TW-1:0] b_i;
   logic          carry_i;
   logic          sub_i;
   logic          valid_o;
   logic          ready_i;
   logic [TW-1:0] result_o;
   logic          carry_o;

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   seq_multiword_adder #(
      .Width  (Width),
      .Chunks (Chunks)
   ) dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .a_i      (a_i),
      .b_i      (b_i),
      .carry_i  (carry_i),
`ifdef SEQ_MULTIWORD_ADDER_SUB_EN
      .sub_i    (sub_i),
`endif
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .result_o (result_o),
      .carry_o  (carry_o)
   );

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Reference: plain wide arithmetic on the whole operands.
   function automatic void ref_model(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                     input logic cin, input logic sub,
                                     output logic [TW-1:0] res, output logic cout);
      logic [TW:0] wide;
      if (!sub) begin
         wide = {1'b0, a} + {1'b0, b} + (TW+1)'(cin);
         res  = wide[TW-1:0];
         cout = wide[TW];
      end else begin
         res  = a - b - TW'(cin);
         cout = ({1'b0, a} >= ({1'b0, b} + (TW+1)'(cin)));
      end
   endfunction

   // Drive one transaction; returns observed result, latency and whether it completed.
   task automatic run_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic cin,
                         input logic sub, input bit early_ack, input bit ack,
                         output logic [TW-1:0] res, output logic cout, output int lat,
                         output int waited, output bit ok);
      ok     = 1'b1;
      waited = 0;
      lat    = 0;
      res    = '0;
      cout   = 1'b0;
      while (!ready_o && waited < 20) begin
         step();
         waited++;
      end
      if (!ready_o) begin
         ok = 1'b0;
         return;
      end
      a_i     = a;
      b_i     = b;
      carry_i = cin;
      sub_i   = sub;
      valid_i = 1'b1;
      if (early_ack) ready_i = 1'b1;
      step();
      valid_i = 1'b0;
      a_i     = TW'($urandom);
      b_i     = TW'($urandom);
      carry_i = 1'($urandom);
      sub_i   = 1'($urandom);
      while (!valid_o && lat < 20) begin
         step();
         lat++;
      end
      if (!valid_o) ok = 1'b0;
      res  = result_o;
      cout = carry_o;
      if (ack) begin
         ready_i = 1'b1;
         step();
         ready_i = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      step();
      step();
      checks++;
      if ({ready_o, valid_o, carry_o, result_o} !== {1'b0, 1'b0, 1'b0, TW'(0)}) begin
         errors++;
         $display("FAIL reset_values: got rdy=%b vld=%b c=%b r=%h want 0 0 0 0000",
                  ready_o, valid_o, carry_o, result_o);
      end
      rst_ni = 1'b1;
      step();
      checks++;
      if (ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b want 1", ready_o);
      end
   endtask

   task automatic test_directed();
      logic [TW-1:0] va [5] = '{16'h0004, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hA5C3};
      logic [TW-1:0] vb [5] = '{16'h000F, 16'h0001, 16'hFFFF, 16'h0000, 16'h5A3D};
      logic          vc [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [TW-1:0] xr [5] = '{16'h0014, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
      logic          xc [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [TW-1:0] res;
      logic          cout;
      int            lat, waited;
      bit            ok;
      for (int i = 0; i < 5; i++) begin
         run_op(va[i], vb[i], vc[i], 1'b0, 1'b0, 1'b1, res, cout, lat, waited, ok);
         checks++;
         if (!ok || res !== xr[i] || cout !== xc[i] || lat != int'(Chunks)) begin
            errors++;
            $display("FAIL directed_%0d: got ok=%0d r=%h c=%b lat=%0d want r=%h c=%b lat=%0d",
                     i, ok, res, cout, lat, xr[i], xc[i], Chunks);
         end
      end
   endtask

   task automatic test_done_hold();
      logic [TW-1:0] res;
      logic          cout;
      int            lat, waited;
      bit            ok;
      run_op(16'h8001, 16'h8002, 1'b1, 1'b0, 1'b0, 1'b0, res, cout, lat, waited, ok);
      checks++;
      if (!ok || res !== 16'h0004 || cout !== 1'b1) begin
         errors++;
         $display("FAIL hold_result: got ok=%0d r=%h c=%b want r=0004 c=1", ok, res, cout);
      end
      for (int i = 0; i < 6; i++) begin
         valid_i = ~valid_i;
         a_i     = TW'($urandom);
         step();
         checks++;
         if ({valid_o, ready_o, carry_o, result_o} !== {1'b1, 1'b0, 1'b1, 16'h0004}) begin
            errors++;
            $display("FAIL hold_cycle_%0d: got vld=%b rdy=%b c=%b r=%h want 1 0 1 0004",
                     i, valid_o, ready_o, carry_o, result_o);
         end
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      step();
      ready_i = 1'b0;
      checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
         errors++;
         $display("FAIL hold_release: got rdy=%b vld=%b want 1 0", ready_o, valid_o);
      end
      // Nothing offered while busy may have been queued.
      repeat (3) step();
      checks++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
         errors++;
         $display("FAIL no_queue: got vld=%b rdy=%b want 0 1", valid_o, ready_o);
      end
   endtask

   task automatic test_reset_abort();
      logic [TW-1:0] res;
      logic          cout;
      int            lat, waited, n;
      bit            ok, spurious;
      n = 0;
      while (!ready_o && n < 20) begin
         step();
         n++;
      end
      a_i     = 16'hFFFF;
      b_i     = 16'h0000;
      carry_i = 1'b0;
      sub_i   = 1'b0;
      valid_i = 1'b1;
      step();
      valid_i = 1'b0;
      step();
      rst_ni = 1'b0;
      step();
      checks++;
      if ({valid_o, ready_o, carry_o, result_o} !== {1'b0, 1'b0, 1'b0, TW'(0)}) begin
         errors++;
         $display("FAIL abort_reset: got vld=%b rdy=%b c=%b r=%h want 0 0 0 0000",
                  valid_o, ready_o, carry_o, result_o);
      end
      rst_ni = 1'b1;
      step();
      checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
         errors++;
         $display("FAIL abort_release: got rdy=%b vld=%b want 1 0", ready_o, valid_o);
      end
      spurious = 1'b0;
      repeat (6) begin
         step();
         if (valid_o !== 1'b0) spurious = 1'b1;
      end
      checks++;
      if (spurious) begin
         errors++;
         $display("FAIL abort_no_partial: got valid_o=1 after abort want 0");
      end
      run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b1, res, cout, lat, waited, ok);
      checks++;
      if (!ok || res !== 16'h2345 || cout !== 1'b0 || lat != int'(Chunks)) begin
         errors++;
         $display("FAIL abort_next_op: got ok=%0d r=%h c=%b lat=%0d want r=2345 c=0 lat=%0d",
                  ok, res, cout, lat, Chunks);
      end
   endtask

   task automatic test_random();
      logic [TW-1:0] a, b, res, xres;
      logic          cin, sub, cout, xcout;
      int            lat, waited;
      bit            ok;
      for (int i = 0; i < 24; i++) begin
         a   = TW'($urandom);
         b   = TW'($urandom);
         cin = 1'($urandom);
`ifdef SEQ_MULTIWORD_ADDER_SUB_EN
         sub = 1'($urandom);
`else
         sub = 1'b0;
`endif
         ref_model(a, b, cin, sub, xres, xcout);
         run_op(a, b, cin, sub, 1'b0, 1'b1, res, cout, lat, waited, ok);
         checks++;
         if (!ok || res !== xres || cout !== xcout || lat != int'(Chunks)) begin
            errors++;
            $display("FAIL random_%0d: a=%h b=%h cin=%b sub=%b got ok=%0d r=%h c=%b lat=%0d want r=%h c=%b",
                     i, a, b, cin, sub, ok, res, cout, lat, xres, xcout);
         end
      end
   endtask

   // ready_i held high throughout: must not disturb ADD; ops run at the minimum interval.
   task automatic test_back_to_back();
      logic [TW-1:0] a, b, res, xres;
      logic          cin, cout, xcout;
      int            lat, waited;
      bit            ok;
      for (int i = 0; i < 8; i++) begin
         a   = TW'($urandom);
         b   = TW'($urandom);
         cin = 1'($urandom);
         ref_model(a, b, cin, 1'b0, xres, xcout);
         run_op(a, b, cin, 1'b0, 1'b1, 1'b1, res, cout, lat, waited, ok);
         checks++;
         if (!ok || res !== xres || cout !== xcout || lat != int'(Chunks)
             || (i > 0 && waited != 0) || valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_%0d: got ok=%0d r=%h c=%b lat=%0d wait=%0d vld=%b rdy=%b want r=%h c=%b lat=%0d wait=0 vld=0 rdy=1",
                     i, ok, res, cout, lat, waited, valid_o, ready_o, xres, xcout, Chunks);
         end
      end
   endtask

`ifdef SEQ_MULTIWORD_ADDER_SUB_EN
   task automatic test_sub();
      logic [TW-1:0] res;
      logic          cout;
      int            lat, waited;
      bit            ok;
      run_op(16'h0010, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1, res, cout, lat, waited, ok);
      checks++;
      if (!ok || res !== 16'h000F || cout !== 1'b1) begin
         errors++;
         $display("FAIL sub_no_borrow: got ok=%0d r=%h c=%b want r=000f c=1", ok, res, cout);
      end
      run_op(16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1, res, cout, lat, waited, ok);
      checks++;
      if (!ok || res !== 16'hFFFF || cout !== 1'b0) begin
         errors++;
         $display("FAIL sub_borrow: got ok=%0d r=%h c=%b want r=ffff c=0", ok, res, cout);
      end
   endtask
`endif

   initial begin
      valid_i = 1'b0;
      ready_i = 1'b0;
      a_i     = '0;
      b_i     = '0;
      carry_i = 1'b0;
      sub_i   = 1'b0;
      test_reset();
      test_directed();
      test_done_hold();
      test_reset_abort();
      test_random();
      test_back_to_back();
`ifdef SEQ_MULTIWORD_ADDER_SUB_EN
      test_sub();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
